// File: rtl/filter3x3_seq.sv
// Frame sequencer for the 3x3 convolution datapath: tracks raster position, drives
// line-buffer/window strobes, injects right/bottom padding and tags emitted centre pixels.
module filter3x3_seq #(
   parameter int unsigned FRAME_H  = 1080,
   parameter int unsigned FRAME_W  = 1920,
   parameter int unsigned WIN_SIZE = 3,
   parameter int unsigned CW       = $clog2(FRAME_W + 1),
   parameter int unsigned RW       = $clog2(FRAME_H + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          s_valid,
   input  logic          s_sof,
   output logic          s_ready,
   input  logic          dp_stall,
   output logic          step,
   output logic          pad,
   output logic          lb_we,
   output logic [CW-1:0] lb_addr,
   output logic          lb_rot,
   output logic          o_valid,
   output logic          o_sof,
   output logic          o_eol,
   output logic          o_eof,
   output logic [3:0]    brd,
   output logic          busy,
   output logic          err_sof
);

   if (WIN_SIZE != 3) begin : g_win_chk
      $error("filter3x3_seq: only WIN_SIZE=3 is supported");
   end
   if (FRAME_H < 2 || FRAME_W < 2) begin : g_dim_chk
      $error("filter3x3_seq: FRAME_H and FRAME_W must be >= 2");
   end

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_RUN   = 2'd1;
   localparam logic [1:0] S_PAD   = 2'd2;
   localparam logic [1:0] S_FLUSH = 2'd3;

   localparam logic [CW-1:0] COL_ONE  = CW'(1);
   localparam logic [CW-1:0] COL_LAST = CW'(FRAME_W - 1);
   localparam logic [CW-1:0] COL_PAD  = CW'(FRAME_W);
   localparam logic [RW-1:0] ROW_ONE  = RW'(1);
   localparam logic [RW-1:0] ROW_LAST = RW'(FRAME_H - 1);
   localparam logic [RW-1:0] ROW_FLSH = RW'(FRAME_H);

   logic [1:0]    state_q, state_d;
   logic [CW-1:0] col_q, col_d;
   logic [RW-1:0] row_q, row_d;
   logic          step_q, step_d;
   logic          pad_q, pad_d;
   logic          lb_we_q, lb_we_d;
   logic [CW-1:0] lb_addr_q, lb_addr_d;
   logic          lb_rot_q, lb_rot_d;
   logic          o_valid_q, o_valid_d;
   logic          o_sof_q, o_sof_d;
   logic          o_eol_q, o_eol_d;
   logic          o_eof_q, o_eof_d;
   logic [3:0]    brd_q, brd_d;
   logic          busy_q, busy_d;
   logic          err_sof_q, err_sof_d;

   logic          acc;
   logic          start;
   logic [RW-1:0] pos_r;
   logic [CW-1:0] pos_c;
   logic          top, bottom, left, right;

   // Next-state, counters and registered strobe computation
   always_comb begin
      state_d   = state_q;
      col_d     = col_q;
      row_d     = row_q;
      step_d    = 1'b0;
      pad_d     = 1'b0;
      lb_we_d   = 1'b0;
      lb_addr_d = '0;
      lb_rot_d  = 1'b0;
      err_sof_d = 1'b0;
      start     = 1'b0;
      pos_r     = row_q;
      pos_c     = col_q;

      s_ready = !dp_stall && (state_q == S_IDLE || state_q == S_RUN);
      acc     = s_valid && s_ready;

      case (state_q)
         S_IDLE: begin
            if (acc && s_sof) start = 1'b1;
         end
         S_RUN: begin
            if (acc && s_sof) begin
               start     = 1'b1;
               err_sof_d = 1'b1;
            end else if (acc) begin
               step_d    = 1'b1;
               lb_we_d   = 1'b1;
               lb_addr_d = col_q;
               col_d     = col_q + COL_ONE;
               if (col_q == COL_LAST) state_d = S_PAD;
            end
         end
         S_PAD: begin
            if (!dp_stall) begin
               step_d    = 1'b1;
               pad_d     = 1'b1;
               lb_rot_d  = 1'b1;
               lb_addr_d = col_q;
               col_d     = '0;
               row_d     = row_q + ROW_ONE;
               state_d   = (row_q == ROW_LAST) ? S_FLUSH : S_RUN;
            end
         end
         S_FLUSH: begin
            if (!dp_stall) begin
               step_d    = 1'b1;
               pad_d     = 1'b1;
               lb_addr_d = col_q;
               col_d     = col_q + COL_ONE;
               if (col_q == COL_PAD) begin
                  lb_rot_d = 1'b1;
                  col_d    = '0;
                  row_d    = '0;
                  state_d  = S_IDLE;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase

      // A frame start (also a resync from RUN) is the step for input (0,0)
      if (start) begin
         step_d    = 1'b1;
         lb_we_d   = 1'b1;
         lb_addr_d = '0;
         pos_r     = '0;
         pos_c     = '0;
         col_d     = COL_ONE;
         row_d     = '0;
         state_d   = S_RUN;
      end

      // Input (r,c) emits centre (r-1,c-1); flags are evaluated in input coordinates
      o_valid_d = step_d && (pos_r != '0) && (pos_c != '0);
      top       = (pos_r == ROW_ONE);
      bottom    = (pos_r == ROW_FLSH);
      left      = (pos_c == COL_ONE);
      right     = (pos_c == COL_PAD);
      brd_d     = o_valid_d ? {top, bottom, left, right} : 4'b0000;
      o_sof_d   = o_valid_d && top && left;
      o_eol_d   = o_valid_d && right;
      o_eof_d   = o_valid_d && bottom && right;
      busy_d    = (state_d != S_IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         col_q     <= '0;
         row_q     <= '0;
         step_q    <= 1'b0;
         pad_q     <= 1'b0;
         lb_we_q   <= 1'b0;
         lb_addr_q <= '0;
         lb_rot_q  <= 1'b0;
         o_valid_q <= 1'b0;
         o_sof_q   <= 1'b0;
         o_eol_q   <= 1'b0;
         o_eof_q   <= 1'b0;
         brd_q     <= 4'b0000;
         busy_q    <= 1'b0;
         err_sof_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         col_q     <= col_d;
         row_q     <= row_d;
         step_q    <= step_d;
         pad_q     <= pad_d;
         lb_we_q   <= lb_we_d;
         lb_addr_q <= lb_addr_d;
         lb_rot_q  <= lb_rot_d;
         o_valid_q <= o_valid_d;
         o_sof_q   <= o_sof_d;
         o_eol_q   <= o_eol_d;
         o_eof_q   <= o_eof_d;
         brd_q     <= brd_d;
         busy_q    <= busy_d;
         err_sof_q <= err_sof_d;
      end
   end

   assign step    = step_q;
   assign pad     = pad_q;
   assign lb_we   = lb_we_q;
   assign lb_addr = lb_addr_q;
   assign lb_rot  = lb_rot_q;
   assign o_valid = o_valid_q;
   assign o_sof   = o_sof_q;
   assign o_eol   = o_eol_q;
   assign o_eof   = o_eof_q;
   assign brd     = brd_q;
   assign busy    = busy_q;
   assign err_sof = err_sof_q;

endmodule

// File: tb/tb_filter3x3_seq.sv
// Directed bench for filter3x3_seq: 4x5 frames (clean, gaps/stalls, drops, resync, reset
// in flush) on one instance and a 2x2 frame on a second instance.
module tb_filter3x3_seq;

   localparam int unsigned H   = 4;
   localparam int unsigned W   = 5;
   localparam int unsigned HB  = 2;
   localparam int unsigned WB  = 2;
   localparam int unsigned CWA = $clog2(W + 1);
   localparam int unsigned CWB = $clog2(WB + 1);

   typedef struct packed {
      logic        pad;
      logic        we;
      logic        rot;
      logic        ov;
      logic        sof;
      logic        eol;
      logic        eof;
      logic [3:0]  brd;
      logic [15:0] addr;
   } rec_t;
   typedef rec_t rec_q_t[$];

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst;
   logic s_valid, s_sof, dp_stall, s_ready, step, pad, lb_we, lb_rot;
   logic o_valid, o_sof, o_eol, o_eof, busy, err_sof;
   logic [CWA-1:0] lb_addr;
   logic [3:0] brd;

   logic s_valid_b, s_sof_b, dp_stall_b, s_ready_b, step_b, pad_b, lb_we_b, lb_rot_b;
   logic o_valid_b, o_sof_b, o_eol_b, o_eof_b, busy_b, err_sof_b;
   logic [CWB-1:0] lb_addr_b;
   logic [3:0] brd_b;

   filter3x3_seq #(.FRAME_H(H), .FRAME_W(W), .WIN_SIZE(3)) dut_a (
      .clk(clk), .rst(rst), .s_valid(s_valid), .s_sof(s_sof), .s_ready(s_ready),
      .dp_stall(dp_stall), .step(step), .pad(pad), .lb_we(lb_we), .lb_addr(lb_addr),
      .lb_rot(lb_rot), .o_valid(o_valid), .o_sof(o_sof), .o_eol(o_eol), .o_eof(o_eof),
      .brd(brd), .busy(busy), .err_sof(err_sof));

   filter3x3_seq #(.FRAME_H(HB), .FRAME_W(WB), .WIN_SIZE(3)) dut_b (
      .clk(clk), .rst(rst), .s_valid(s_valid_b), .s_sof(s_sof_b), .s_ready(s_ready_b),
      .dp_stall(dp_stall_b), .step(step_b), .pad(pad_b), .lb_we(lb_we_b), .lb_addr(lb_addr_b),
      .lb_rot(lb_rot_b), .o_valid(o_valid_b), .o_sof(o_sof_b), .o_eol(o_eol_b), .o_eof(o_eof_b),
      .brd(brd_b), .busy(busy_b), .err_sof(err_sof_b));

   int n_cmp = 0;
   int n_bad = 0;
   int stall_viol = 0;
   int bad_ready = 0;
   bit stall_mode = 0;
   bit gap_mode = 0;
   logic stall_at_edge = 1'b0;
   rec_q_t got_a;
   rec_q_t got_b;

   // Log every step of each instance
   always @(posedge clk) stall_at_edge <= dp_stall;

   always @(negedge clk) begin
      rec_t r;
      if (step) begin
         r = {pad, lb_we, lb_rot, o_valid, o_sof, o_eol, o_eof, brd,
              (lb_we ? 16'(lb_addr) : 16'd0)};
         got_a.push_back(r);
         if (stall_at_edge) stall_viol++;
      end
      if (step_b) begin
         r = {pad_b, lb_we_b, lb_rot_b, o_valid_b, o_sof_b, o_eol_b, o_eof_b, brd_b,
              (lb_we_b ? 16'(lb_addr_b) : 16'd0)};
         got_b.push_back(r);
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Expected step sequence, written in terms of the emitted centre (cr,cc)
   function automatic rec_q_t build_exp(int h, int w);
      rec_q_t q;
      rec_t e;
      int cr, cc;
      for (int r = 0; r <= h; r++) begin
         for (int c = 0; c <= w; c++) begin
            e = '0;
            e.pad  = (c == w) || (r == h);
            e.we   = !e.pad;
            e.addr = e.we ? 16'(c) : 16'd0;
            e.rot  = (c == w);
            cr = r - 1;
            cc = c - 1;
            e.ov = (cr >= 0) && (cc >= 0);
            if (e.ov) begin
               e.brd = {cr == 0, cr == h - 1, cc == 0, cc == w - 1};
               e.sof = (cr == 0) && (cc == 0);
               e.eol = (cc == w - 1);
               e.eof = (cr == h - 1) && (cc == w - 1);
            end
            q.push_back(e);
         end
      end
      return q;
   endfunction

   task automatic compare_frame(input string tag, input rec_q_t got, input int h, input int w,
                                input int e_steps, input int e_ov, input int e_we, input int e_rot);
      rec_q_t exp;
      int n_ov, n_we, n_rot;
      exp = build_exp(h, w);
      n_ov = 0; n_we = 0; n_rot = 0;
      foreach (got[i]) begin
         n_ov  += int'(got[i].ov);
         n_we  += int'(got[i].we);
         n_rot += int'(got[i].rot);
      end
      chk({tag, "_steps"}, 32'(got.size()), 32'(e_steps));
      chk({tag, "_ovalid"}, 32'(n_ov), 32'(e_ov));
      chk({tag, "_lbwe"}, 32'(n_we), 32'(e_we));
      chk({tag, "_lbrot"}, 32'(n_rot), 32'(e_rot));
      for (int i = 0; i < exp.size() && i < got.size(); i++)
         chk($sformatf("%s_step%0d", tag, i), 32'(got[i]), 32'(exp[i]));
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
      dp_stall = stall_mode && ($urandom_range(99, 0) < 35);
   endtask

   task automatic send_beat(input logic sof, input bit chk_pad);
      int n;
      bit got;
      n = 0;
      got = 0;
      s_valid = 1'b1;
      s_sof = sof;
      while (!got && n < 100) begin
         @(negedge clk);
         got = s_ready;
         cyc();
         n++;
      end
      s_valid = 1'b0;
      s_sof = 1'b0;
      chk("accept", 32'(got), 32'd1);
      if (chk_pad) chk("ready_in_pad", 32'(s_ready), 32'd0);
      if (gap_mode && $urandom_range(1, 0) == 1) cyc();
   endtask

   task automatic drive_beats(input int r0, input int c0, input int n);
      int r, c;
      r = r0;
      c = c0;
      repeat (n) begin
         send_beat(r == 0 && c == 0, c == int'(W) - 1);
         c++;
         if (c == int'(W)) begin
            c = 0;
            r++;
         end
      end
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (busy && n < 300) begin
         if (s_ready) bad_ready++;
         cyc();
         n++;
      end
      chk("idle_reached", 32'(busy), 32'd0);
      cyc();
   endtask

   initial begin
      int first_ov, acc_n, n;
      rst = 1'b1;
      s_valid = 0; s_sof = 0; dp_stall = 0;
      s_valid_b = 0; s_sof_b = 0; dp_stall_b = 0;
      repeat (3) cyc();
      chk("rst_step", 32'(step), 32'd0);
      chk("rst_sready", 32'(s_ready), 32'd1);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_outs", 32'({pad, lb_we, lb_rot, o_valid, o_sof, o_eol, o_eof, err_sof}), 32'd0);
      chk("rst_addr_brd", 32'({lb_addr, brd}), 32'd0);
      rst = 1'b0;
      cyc();

      // Clean frame, source always valid
      got_a.delete();
      drive_beats(0, 0, H * W);
      wait_idle();
      compare_frame("clean", got_a, H, W, 30, 20, 20, 5);
      first_ov = -1;
      foreach (got_a[i]) if (first_ov < 0 && got_a[i].ov) first_ov = i;
      chk("clean_first_ov_idx", 32'(first_ov), 32'd7);
      chk("clean_first_ov_flags", 32'({got_a[7].sof, got_a[7].brd}), 32'b1_1010);
      chk("clean_last_flags", 32'({got_a[29].eof, got_a[29].brd}), 32'b1_0101);
      chk("clean_ready_low", 32'(bad_ready), 32'd0);

      // Random source gaps and datapath stall bursts
      stall_mode = 1; gap_mode = 1;
      got_a.delete();
      drive_beats(0, 0, H * W);
      wait_idle();
      stall_mode = 0; gap_mode = 0; dp_stall = 0;
      cyc();
      compare_frame("gapstall", got_a, H, W, 30, 20, 20, 5);
      chk("stall_no_step", 32'(stall_viol), 32'd0);
      chk("stall_ready_low", 32'(bad_ready), 32'd0);

      // Beats without sof in IDLE are dropped
      got_a.delete();
      s_valid = 1'b1; s_sof = 1'b0;
      repeat (3) begin
         cyc();
         chk("drop_step", 32'(step), 32'd0);
         chk("drop_busy", 32'(busy), 32'd0);
      end
      s_valid = 1'b0;
      send_beat(1'b1, 1'b0);
      chk("start_step_we", 32'({step, lb_we, o_valid}), 32'b110);
      chk("start_addr", 32'(lb_addr), 32'd0);
      drive_beats(0, 1, H * W - 1);
      wait_idle();
      compare_frame("dropstart", got_a, H, W, 30, 20, 20, 5);

      // Unexpected sof at input (2,3) resynchronises the frame
      drive_beats(0, 0, 2 * W + 3);
      cyc();
      got_a.delete();
      send_beat(1'b1, 1'b0);
      chk("resync_err", 32'(err_sof), 32'd1);
      chk("resync_step", 32'({step, lb_we, o_valid}), 32'b110);
      chk("resync_addr", 32'(lb_addr), 32'd0);
      cyc();
      chk("resync_err_pulse", 32'(err_sof), 32'd0);
      drive_beats(0, 1, H * W - 1);
      wait_idle();
      compare_frame("resync", got_a, H, W, 30, 20, 20, 5);

      // Reset while flushing at column 2
      got_a.delete();
      drive_beats(0, 0, H * W);
      repeat (3) cyc();
      chk("flush_busy", 32'({busy, step, pad}), 32'b111);
      rst = 1'b1;
      cyc();
      chk("flushrst_ready", 32'(s_ready), 32'd1);
      chk("flushrst_busy", 32'(busy), 32'd0);
      chk("flushrst_step_eof", 32'({step, o_eof}), 32'd0);
      rst = 1'b0;
      repeat (3) begin
         cyc();
         chk("postrst_quiet", 32'({step, o_eof, busy}), 32'd0);
      end
      chk("flushrst_steps", 32'(got_a.size()), 32'd26);
      got_a.delete();
      drive_beats(0, 0, H * W);
      wait_idle();
      compare_frame("postrst", got_a, H, W, 30, 20, 20, 5);

      // 2x2 frame on the second instance
      got_b.delete();
      acc_n = 0; n = 0;
      s_valid_b = 1'b1; s_sof_b = 1'b1;
      while (acc_n < int'(HB * WB) && n < 100) begin
         @(negedge clk);
         if (s_ready_b) acc_n++;
         @(posedge clk);
         #1;
         if (acc_n >= 1) s_sof_b = 1'b0;
         if (acc_n == int'(HB * WB)) s_valid_b = 1'b0;
         n++;
      end
      s_valid_b = 1'b0;
      chk("small_accepts", 32'(acc_n), 32'(HB * WB));
      n = 0;
      while (busy_b && n < 100) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk("small_idle", 32'(busy_b), 32'd0);
      cyc();
      compare_frame("small", got_b, HB, WB, 9, 4, 4, 3);
      foreach (got_b[i])
         if (got_b[i].ov) chk($sformatf("small_two_borders%0d", i), 32'($countones(got_b[i].brd)), 32'd2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/filter3x3_seq.md
Name: filter3x3_seq

Overview:
- Frame sequencer for the 3x3 convolution datapath.
- Accepts the raster pixel stream handshake and tracks input row/column.
- Drives line-buffer write/rotate, window-shift strobes and pad injection for the right and bottom borders.
- Tags each emitted centre pixel with border flags and sof/eol/eof so the datapath can replicate edges and produce exactly FRAME_H*FRAME_W outputs per frame.

Parameters:
- FRAME_H, 1080, active rows per frame (>=2).
- FRAME_W, 1920, active pixels per row (>=2).
- WIN_SIZE, 3, window size; only 3 is supported (elaboration error otherwise).
- CW, $clog2(FRAME_W+1), column counter width.
- RW, $clog2(FRAME_H+1), row counter width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active high
- s_valid  in  1  input pixel valid (pixel data bypasses this block straight to the datapath)
- s_sof  in  1  qualifies first pixel of frame, sampled with s_valid
- s_ready  out  1  block accepts a pixel this cycle
- dp_stall  in  1  datapath freeze request
- step  out  1  registered strobe: datapath shifts the window one column
- pad  out  1  with step: no new pixel; datapath replicates the last column/row
- lb_we  out  1  with step: write the incoming pixel to the line buffer at lb_addr
- lb_addr  out  CW  line-buffer column address
- lb_rot  out  1  with the last step of each row: rotate line buffers
- o_valid  out  1  with step: a centre pixel is emitted
- o_sof  out  1  emitted pixel is (0,0)
- o_eol  out  1  emitted pixel is in the last column
- o_eof  out  1  emitted pixel is (H-1,W-1)
- brd  out  4  {top,bottom,left,right} border flags of the emitted pixel
- busy  out  1  a frame is in progress
- err_sof  out  1  one-cycle pulse: s_sof seen mid-frame

Behaviour:
- Reset: state=IDLE, row=col=0. All outputs 0, except s_ready=1.
- Counters: col 0..FRAME_W, row 0..FRAME_H. Column FRAME_W is the pad column; row FRAME_H is the flush row.
- Accept: acc = s_valid & s_ready. s_ready = !dp_stall & (state==IDLE | state==RUN), combinational.
- Outputs step, pad, lb_we, lb_addr, lb_rot, o_*, brd are registered and appear one cycle after the accept or internal advance. They are 0 on cycles with no advance.
- IDLE:
  - acc with s_sof: col=1, row=0, state=RUN, step with lb_we, lb_addr=0, o_valid=0.
  - acc without s_sof: beat dropped, no step.
- RUN:
  - acc advances col.
  - If the accepted beat was col W-1, the next state is PAD.
- PAD (s_ready=0):
  - One advance when !dp_stall: step with pad=1, lb_we=0, lb_rot=1.
  - Then col=0 and row++.
  - Next state is FLUSH if the new row==FRAME_H, else RUN.
- FLUSH (s_ready=0):
  - One advance per !dp_stall cycle.
  - Each advance: step, pad=1, lb_we=0, col++.
  - The advance at col=W: lb_rot=1, o_eof=1, then state=IDLE with row=col=0.
- Emission: a step for input position (r,c) has o_valid = (r>=1 & c>=1). The emitted centre is (r-1,c-1).
- Border flags and markers for the emitted centre (cr,cc):
  - top=(cr==0), bottom=(cr==H-1), left=(cc==0), right=(cc==W-1).
  - o_sof=(cr==0 & cc==0); o_eol=right; o_eof=(cr==H-1 & cc==W-1).
- Frame totals: steps = (H+1)*(W+1); o_valid steps = H*W; lb_we steps = H*W; lb_rot pulses = H+1.
- dp_stall=1: no advance and no step; state and counters hold. Internal states hold too.
- s_sof in RUN:
  - err_sof pulses.
  - The pixel is taken as (0,0): col=1, row=0, step with lb_we, addr 0, o_valid=0.
  - Partial-frame outputs are abandoned.
- s_sof while s_ready=0 (PAD/FLUSH): not accepted; the source holds it.
- busy = (state!=IDLE), registered.
- rst mid-frame: returns to IDLE next cycle, all strobes 0, no flush.
- rst has priority over all other events.

Test Plan (H=4, W=5 unless stated):
- Clean frame, s_valid always 1 -> 30 steps, 20 o_valid, 20 lb_we, 5 lb_rot. First o_valid at the step for input (1,1) with o_sof=1, brd=1010. o_eof once on the last FLUSH step with brd=0101.
- Random s_valid gaps (50%) and dp_stall bursts -> same 30-step sequence and flags as the clean frame. No step while dp_stall=1. s_ready=0 during PAD/FLUSH.
- Beats without s_sof in IDLE -> dropped, no step, busy=0. A following s_sof beat starts the frame with lb_addr=0.
- s_sof at input (2,3) -> err_sof pulse. Counters restart, and the next full frame yields exactly 20 o_valid.
- rst asserted during FLUSH at col=2 -> next cycle state IDLE, s_ready=1, no o_eof. A new frame completes normally.
- H=2, W=2 -> 9 steps, 4 o_valid, and every emitted pixel has exactly two border flags set.
